// File: rtl/decode_alu_unit.sv
// Purpose: MIPS ID-stage instruction decoder plus EX-stage 32-bit ALU, with a sticky halt flag.
// Latency: decode and ALU are combinational (0 cycles); halt_q is set one CLK edge after HALT decodes.
// Backpressure: none; outputs follow the inputs every cycle and stalls are handled by the pipeline registers.
//
// Ports:
//   CLK, nRST            rising-edge clock, synchronous active-low reset (clears halt_q only)
//   instruction          IF/ID instruction word; field outputs are plain slices of it
//   alu_op, port_a/b     ALU operation and forwarded operands from EX
//   rs..immediate26      instruction field extracts, imm_ext = extended immediate
//   ALUctr..PCSrc        decoded control bits for the datapath
//   halt                 decoded HALT or the sticky halt_q
//   alu_out, flags       ALU result, negative / overflow / zero
module decode_alu_unit (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] instruction,
  input  logic [3:0]  alu_op,
  input  logic [31:0] port_a,
  input  logic [31:0] port_b,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [15:0] immediate,
  output logic [31:0] imm_ext,
  output logic [25:0] immediate26,
  output logic [3:0]  ALUctr,
  output logic [1:0]  RegDst,
  output logic [1:0]  ALUSrc,
  output logic        ALUSrc2,
  output logic [1:0]  MemToReg,
  output logic        RegWr,
  output logic        dREN,
  output logic        dWEN,
  output logic        Branch,
  output logic        BranchNEQ,
  output logic        Jump,
  output logic        ExtOp,
  output logic [1:0]  PCSrc,
  output logic        halt,
  output logic [31:0] alu_out,
  output logic        negative,
  output logic        overflow,
  output logic        zero
);

  // aluop_t encodings shared with the datapath
  localparam logic [3:0] ALU_SLL  = 4'd0;
  localparam logic [3:0] ALU_SRL  = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd10;
  localparam logic [3:0] ALU_SLTU = 4'd11;

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic        w_dec_halt;
  logic        r_halt;
  logic [31:0] w_sum;
  logic [31:0] w_diff;

  assign w_opcode    = instruction[31:26];
  assign w_funct     = instruction[5:0];
  assign rs          = instruction[25:21];
  assign rt          = instruction[20:16];
  assign rd          = instruction[15:11];
  assign shamt       = instruction[10:6];
  assign immediate   = instruction[15:0];
  assign immediate26 = instruction[25:0];
  assign imm_ext     = ExtOp ? {{16{instruction[15]}}, instruction[15:0]}
                             : {16'h0000, instruction[15:0]};

  // ---------------------------------------------------------------- decode
  always_comb begin
    ALUctr     = ALU_ADD;
    RegDst     = 2'd0;
    ALUSrc     = 2'd0;
    ALUSrc2    = 1'b0;
    MemToReg   = 2'd0;
    RegWr      = 1'b0;
    dREN       = 1'b0;
    dWEN       = 1'b0;
    Branch     = 1'b0;
    BranchNEQ  = 1'b0;
    Jump       = 1'b0;
    ExtOp      = 1'b0;
    PCSrc      = 2'd0;
    w_dec_halt = 1'b0;
    case (w_opcode)
      6'h00: begin
        RegDst = 2'd1;
        RegWr  = 1'b1;
        case (w_funct)
          6'h00: begin ALUctr = ALU_SLL; ALUSrc = 2'd1; ALUSrc2 = 1'b1; end
          6'h02: begin ALUctr = ALU_SRL; ALUSrc = 2'd1; ALUSrc2 = 1'b1; end
          6'h20, 6'h21: ALUctr = ALU_ADD;
          6'h22, 6'h23: ALUctr = ALU_SUB;
          6'h24: ALUctr = ALU_AND;
          6'h25: ALUctr = ALU_OR;
          6'h26: ALUctr = ALU_XOR;
          6'h27: ALUctr = ALU_NOR;
          6'h2A: ALUctr = ALU_SLT;
          6'h2B: ALUctr = ALU_SLTU;
          6'h08: begin RegWr = 1'b0; PCSrc = 2'd3; end
          default: RegWr = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin ALUSrc = 2'd1; ExtOp = 1'b1; RegWr = 1'b1; end
      6'h0A: begin ALUctr = ALU_SLT;  ALUSrc = 2'd1; ExtOp = 1'b1; RegWr = 1'b1; end
      6'h0B: begin ALUctr = ALU_SLTU; ALUSrc = 2'd1; ExtOp = 1'b1; RegWr = 1'b1; end
      6'h0C: begin ALUctr = ALU_AND;  ALUSrc = 2'd1; RegWr = 1'b1; end
      6'h0D: begin ALUctr = ALU_OR;   ALUSrc = 2'd1; RegWr = 1'b1; end
      6'h0E: begin ALUctr = ALU_XOR;  ALUSrc = 2'd1; RegWr = 1'b1; end
      // LUI: the datapath feeds port_a=$0, so OR with {imm,16'b0} yields the upper immediate
      6'h0F: begin ALUctr = ALU_OR;   ALUSrc = 2'd2; RegWr = 1'b1; end
      6'h23: begin ALUSrc = 2'd1; ExtOp = 1'b1; dREN = 1'b1; MemToReg = 2'd1; RegWr = 1'b1; end
      6'h2B: begin ALUSrc = 2'd1; ExtOp = 1'b1; dWEN = 1'b1; end
      // Branches resolve in EX from the zero flag, so PCSrc stays at pc+4 here
      6'h04: begin Branch = 1'b1;    ALUctr = ALU_SUB; ExtOp = 1'b1; end
      6'h05: begin BranchNEQ = 1'b1; ALUctr = ALU_SUB; ExtOp = 1'b1; end
      6'h02: begin Jump = 1'b1; PCSrc = 2'd1; end
      6'h03: begin
        Jump = 1'b1; PCSrc = 2'd1; RegDst = 2'd2; MemToReg = 2'd2; RegWr = 1'b1;
      end
      6'h3F: w_dec_halt = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- halt
  // Reset wins over a HALT decoded on the same edge.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_halt <= 1'b0;
    end else if (w_dec_halt) begin
      r_halt <= 1'b1;
    end
  end

  assign halt = w_dec_halt | r_halt;

  // ---------------------------------------------------------------- ALU
  assign w_sum  = port_a + port_b;
  assign w_diff = port_a - port_b;

  always_comb begin
    alu_out  = 32'h0;
    overflow = 1'b0;
    case (alu_op)
      ALU_SLL:  alu_out = port_a << port_b[4:0];
      ALU_SRL:  alu_out = port_a >> port_b[4:0];
      ALU_ADD: begin
        alu_out  = w_sum;
        overflow = (port_a[31] == port_b[31]) && (w_sum[31] != port_a[31]);
      end
      ALU_SUB: begin
        alu_out  = w_diff;
        overflow = (port_a[31] != port_b[31]) && (w_diff[31] != port_a[31]);
      end
      ALU_AND:  alu_out = port_a & port_b;
      ALU_OR:   alu_out = port_a | port_b;
      ALU_XOR:  alu_out = port_a ^ port_b;
      ALU_NOR:  alu_out = ~(port_a | port_b);
      ALU_SLT:  alu_out = {31'h0, ($signed(port_a) < $signed(port_b))};
      ALU_SLTU: alu_out = {31'h0, (port_a < port_b)};
      default:  alu_out = 32'h0;
    endcase
  end

  assign zero     = (alu_out == 32'h0);
  assign negative = alu_out[31];

endmodule

// File: tb/tb_decode_alu_unit.sv
module tb_decode_alu_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] instruction;
  logic [3:0]  alu_op;
  logic [31:0] port_a, port_b;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] immediate;
  logic [31:0] imm_ext;
  logic [25:0] immediate26;
  logic [3:0]  ALUctr;
  logic [1:0]  RegDst, ALUSrc, MemToReg, PCSrc;
  logic        ALUSrc2, RegWr, dREN, dWEN, Branch, BranchNEQ, Jump, ExtOp, halt;
  logic [31:0] alu_out;
  logic        negative, overflow, zero;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  decode_alu_unit dut (
    .CLK(CLK), .nRST(nRST), .instruction(instruction), .alu_op(alu_op),
    .port_a(port_a), .port_b(port_b), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .immediate(immediate), .imm_ext(imm_ext), .immediate26(immediate26),
    .ALUctr(ALUctr), .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUSrc2(ALUSrc2),
    .MemToReg(MemToReg), .RegWr(RegWr), .dREN(dREN), .dWEN(dWEN),
    .Branch(Branch), .BranchNEQ(BranchNEQ), .Jump(Jump), .ExtOp(ExtOp),
    .PCSrc(PCSrc), .halt(halt), .alu_out(alu_out), .negative(negative),
    .overflow(overflow), .zero(zero)
  );

  // Decode vector: instruction plus expected controls and extended immediate.
  typedef struct {
    logic [31:0] instr;
    logic [1:0]  regdst, alusrc;
    logic        alusrc2;
    logic [1:0]  memtoreg;
    logic        regwr, dren, dwen, br, bne, jump, ext;
    logic [1:0]  pcsrc;
    logic [3:0]  aluctr;
    logic [31:0] imm;
  } dvec_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic        n, v, z;
  } avec_t;

  dvec_t dv[$];
  avec_t av[$];

  function automatic dvec_t mkd(logic [31:0] instr, logic [1:0] regdst, logic [1:0] alusrc,
                                logic alusrc2, logic [1:0] memtoreg, logic regwr, logic dren,
                                logic dwen, logic br, logic bne, logic jump, logic ext,
                                logic [1:0] pcsrc, logic [3:0] aluctr, logic [31:0] imm);
    dvec_t d;
    d.instr = instr; d.regdst = regdst; d.alusrc = alusrc; d.alusrc2 = alusrc2;
    d.memtoreg = memtoreg; d.regwr = regwr; d.dren = dren; d.dwen = dwen; d.br = br;
    d.bne = bne; d.jump = jump; d.ext = ext; d.pcsrc = pcsrc; d.aluctr = aluctr; d.imm = imm;
    return d;
  endfunction

  function automatic avec_t mka(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                logic [31:0] res, logic n, logic v, logic z);
    avec_t x;
    x.op = op; x.a = a; x.b = b; x.res = res; x.n = n; x.v = v; x.z = z;
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [63:0] ctl_now();
    return {24'h0, RegDst, ALUSrc, ALUSrc2, MemToReg, RegWr, dREN, dWEN, Branch,
            BranchNEQ, Jump, ExtOp, PCSrc, ALUctr, imm_ext};
  endfunction

  function automatic logic [63:0] ctl_exp(dvec_t d);
    return {24'h0, d.regdst, d.alusrc, d.alusrc2, d.memtoreg, d.regwr, d.dren, d.dwen,
            d.br, d.bne, d.jump, d.ext, d.pcsrc, d.aluctr, d.imm};
  endfunction

  initial begin
    //           instr         RD   SRC  S2 M2R  RW DR DW BR BN J  EX PC   ALU    imm
    dv.push_back(mkd(32'h2001FFFF, 2'd0, 2'd1, 0, 2'd0, 1, 0, 0, 0, 0, 0, 1, 2'd0, 4'd2,  32'hFFFFFFFF)); // ADDI
    dv.push_back(mkd(32'h3401FFFF, 2'd0, 2'd1, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 4'd5,  32'h0000FFFF)); // ORI
    dv.push_back(mkd(32'h8C220004, 2'd0, 2'd1, 0, 2'd1, 1, 1, 0, 0, 0, 0, 1, 2'd0, 4'd2,  32'h00000004)); // LW
    dv.push_back(mkd(32'hAC220004, 2'd0, 2'd1, 0, 2'd0, 0, 0, 1, 0, 0, 0, 1, 2'd0, 4'd2,  32'h00000004)); // SW
    dv.push_back(mkd(32'h0C000010, 2'd2, 2'd0, 0, 2'd2, 1, 0, 0, 0, 0, 1, 0, 2'd1, 4'd2,  32'h00000010)); // JAL
    dv.push_back(mkd(32'h10220003, 2'd0, 2'd0, 0, 2'd0, 0, 0, 0, 1, 0, 0, 1, 2'd0, 4'd3,  32'h00000003)); // BEQ
    dv.push_back(mkd(32'h14220003, 2'd0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 1, 2'd0, 4'd3,  32'h00000003)); // BNE
    dv.push_back(mkd(32'h03E00008, 2'd1, 2'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 4'd2,  32'h00000008)); // JR
    dv.push_back(mkd(32'h00221820, 2'd1, 2'd0, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 4'd2,  32'h00001820)); // ADD
    dv.push_back(mkd(32'h00011100, 2'd1, 2'd1, 1, 2'd0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 4'd0,  32'h00001100)); // SLL
    dv.push_back(mkd(32'h0022182B, 2'd1, 2'd0, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 4'd11, 32'h0000182B)); // SLTU
    dv.push_back(mkd(32'h3C011234, 2'd0, 2'd2, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 4'd5,  32'h00001234)); // LUI
    dv.push_back(mkd(32'h2821FFFF, 2'd0, 2'd1, 0, 2'd0, 1, 0, 0, 0, 0, 0, 1, 2'd0, 4'd10, 32'hFFFFFFFF)); // SLTI
    dv.push_back(mkd(32'h3821FFFF, 2'd0, 2'd1, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 4'd6,  32'h0000FFFF)); // XORI
    dv.push_back(mkd(32'h08000010, 2'd0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 2'd1, 4'd2,  32'h00000010)); // J
    dv.push_back(mkd(32'hF8000000, 2'd0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 4'd2,  32'h00000000)); // bad opcode
    dv.push_back(mkd(32'h0000003F, 2'd1, 2'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 4'd2,  32'h0000003F)); // bad funct

    //              op     a             b             result        n  v  z
    av.push_back(mka(4'd2,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1, 1, 0));
    av.push_back(mka(4'd3,  32'h00000005, 32'h00000005, 32'h00000000, 0, 0, 1));
    av.push_back(mka(4'd10, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0));
    av.push_back(mka(4'd11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, 0, 1));
    av.push_back(mka(4'd10, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 0, 0, 1));
    av.push_back(mka(4'd11, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0));
    av.push_back(mka(4'd0,  32'h00000001, 32'h0000001F, 32'h80000000, 1, 0, 0));
    av.push_back(mka(4'd1,  32'h80000000, 32'h0000003F, 32'h00000001, 0, 0, 0));
    av.push_back(mka(4'd7,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1, 0, 0));
    av.push_back(mka(4'd3,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 0));
    av.push_back(mka(4'd2,  32'h80000000, 32'h80000000, 32'h00000000, 0, 1, 1));
    av.push_back(mka(4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1, 0, 0));
    av.push_back(mka(4'd5,  32'h12340000, 32'h00005678, 32'h12345678, 0, 0, 0));
    av.push_back(mka(4'd6,  32'hFFFFFFFF, 32'h0F0F0F0F, 32'hF0F0F0F0, 1, 0, 0));
    av.push_back(mka(4'd8,  32'h00000005, 32'h00000005, 32'h00000000, 0, 0, 1));

    alu_op = 4'd0; port_a = 32'h0; port_b = 32'h0;

    // Reset state and sticky halt behaviour
    nRST = 1'b0; instruction = 32'h0;
    tick();
    check("reset_halt", {63'h0, halt}, 64'h0);
    nRST = 1'b1;
    instruction = 32'hFC000000;
    #1;
    check("halt_decoded", {63'h0, halt}, 64'h1);
    check("halt_ctl_zero", ctl_now(),
          ctl_exp(mkd(32'hFC000000, 2'd0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 4'd2, 32'h0)));
    tick();
    instruction = 32'h0;
    #1;
    check("halt_sticky", {63'h0, halt}, 64'h1);
    tick(); tick(); tick();
    check("halt_hold", {63'h0, halt}, 64'h1);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    check("halt_cleared", {63'h0, halt}, 64'h0);
    // Reset and HALT on the same edge: reset wins
    nRST = 1'b0; instruction = 32'hFC000000;
    tick();
    instruction = 32'h0;
    #1;
    check("halt_rst_prio", {63'h0, halt}, 64'h0);
    nRST = 1'b1;
    tick();

    // Field extracts
    instruction = 32'h8C220004; #1;
    check("fields_lw", {18'h0, rs, rt, rd, shamt, immediate}, {18'h0, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0004});
    check("imm26_lw", {38'h0, immediate26}, {38'h0, 26'h0220004});
    instruction = 32'h00011100; #1;
    check("fields_sll", {18'h0, rs, rt, rd, shamt, immediate}, {18'h0, 5'd0, 5'd1, 5'd2, 5'd4, 16'h1100});
    instruction = 32'h0C000010; #1;
    check("imm26_jal", {38'h0, immediate26}, {38'h0, 26'h0000010});

    // Decode table
    foreach (dv[i]) begin
      instruction = dv[i].instr;
      #1;
      check($sformatf("dec[%0d]_%h", i, dv[i].instr), ctl_now(), ctl_exp(dv[i]));
      check($sformatf("nohalt[%0d]", i), {63'h0, halt}, 64'h0);
    end

    // ALU table
    foreach (av[i]) begin
      alu_op = av[i].op; port_a = av[i].a; port_b = av[i].b;
      #1;
      check($sformatf("alu[%0d]_op%0d", i, av[i].op), {29'h0, negative, overflow, zero, alu_out},
            {29'h0, av[i].n, av[i].v, av[i].z, av[i].res});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
